// File: rtl/serial_neg_ctrl.sv
// -----------------------------------------------------------------------------
// serial_neg_ctrl
//
// Word-level sequencer for a bit-serial two's-complement unit. It accepts a
// parallel word, clears the serial complementer, streams the word LSB-first
// into it, reassembles the returned serial bits, and presents the negated
// word with an overflow flag on an output valid/ready handshake.
//
// Parameters:
//   W      word width in bits (W >= 2)
//   Y_LAT  cycles from driving ser_i to the matching bit on ser_y (0 or 1)
//
// Ports:
//   t_clk      system clock, rising edge
//   r_n        synchronous active-low reset
//   in_valid   in_data is valid
//   in_ready   block can accept a word (high only in IDLE)
//   in_data    word to negate
//   ser_i      serial bit to the complementer, LSB first
//   ser_r      active-high clear to the complementer (high in IDLE and DONE)
//   ser_y      serial result bit from the complementer
//   out_valid  result is valid (high only in DONE)
//   out_ready  consumer accepts the result
//   out_data   two's complement of the accepted word
//   out_ovf    accepted word was the most-negative value
//   out_err    (SERIAL_NEG_SELFCHECK_EN only) serial result disagrees with a
//              parallel recomputation; valid in DONE, cleared on leaving it
//
// Optional feature macro: SERIAL_NEG_SELFCHECK_EN
// -----------------------------------------------------------------------------
module serial_neg_ctrl #(
  parameter int W     = 8,
  parameter int Y_LAT = 0
) (
  input  logic         t_clk,
  input  logic         r_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         ser_i,
  output logic         ser_r,
  input  logic         ser_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
`ifdef SERIAL_NEG_SELFCHECK_EN
  output logic         out_ovf,
  output logic         out_err
`else
  output logic         out_ovf
`endif
);

  localparam int            CW       = $clog2(W);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};
  // With a registered complementer every sample lags its drive by one cycle.
  localparam bit            LAT1     = (Y_LAT != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [W-1:0]  shift_r, shift_s;
  logic [W-1:0]  result_r, result_s;
  logic          ovf_r, ovf_s;

  // Parallel two's complement, used only by the optional self-check.
  function automatic logic [W-1:0] neg_f(input logic [W-1:0] v);
    return (~v) + {{(W-1){1'b0}}, 1'b1};
  endfunction

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    shift_s  = shift_r;
    result_s = result_r;
    ovf_s    = ovf_r;
    case (state_r)
      IDLE: begin
        // in_ready is 1 in IDLE, so in_valid alone completes the handshake.
        if (in_valid) begin
          state_s = SHIFT;
          shift_s = in_data;
          ovf_s   = (in_data == MOST_NEG);
          cnt_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        shift_s = {1'b0, shift_r[W-1:1]};
        cnt_s   = cnt_r + CNT_ONE;
        // With Y_LAT=1 the first SHIFT cycle sees the cleared output of the
        // complementer, not a result bit, so it is skipped; DRAIN takes the
        // last bit instead, keeping exactly W samples per word.
        if (!LAT1 || (cnt_r != '0)) begin
          result_s = {ser_y, result_r[W-1:1]};
        end else begin
          result_s = result_r;
        end
        if (cnt_r == LAST_CNT) begin
          state_s = LAT1 ? DRAIN : DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DRAIN: begin
        result_s = {ser_y, result_r[W-1:1]};
        state_s  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge t_clk) begin
    if (!r_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      shift_r  <= '0;
      result_r <= '0;
      ovf_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      shift_r  <= shift_s;
      result_r <= result_s;
      ovf_r    <= ovf_s;
    end
  end

  // Handshake and serial-interface outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    ser_r     = 1'b0;
    ser_i     = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        ser_r    = 1'b1;
      end
      SHIFT: begin
        ser_i = shift_r[0];
      end
      DRAIN: begin
        ser_i = 1'b0;
      end
      DONE: begin
        out_valid = 1'b1;
        ser_r     = 1'b1;
      end
      default: begin
        ser_r = 1'b1;
      end
    endcase
  end

  assign out_data = result_r;
  assign out_ovf  = ovf_r;

`ifdef SERIAL_NEG_SELFCHECK_EN
  logic [W-1:0] copy_r, copy_s;
  logic         err_r, err_s;

  // Capture a copy of the accepted word and judge the serial result once,
  // on the transition into DONE; the verdict is held there and dropped after.
  always_comb begin
    copy_s = copy_r;
    err_s  = 1'b0;
    if ((state_r == IDLE) && in_valid) begin
      copy_s = in_data;
    end else begin
      copy_s = copy_r;
    end
    if ((state_s == DONE) && (state_r != DONE)) begin
      err_s = (result_s != neg_f(copy_s));
    end else if (state_s == DONE) begin
      err_s = err_r;
    end else begin
      err_s = 1'b0;
    end
  end

  // Self-check registers with synchronous active-low reset.
  always_ff @(posedge t_clk) begin
    if (!r_n) begin
      copy_r <= '0;
      err_r  <= 1'b0;
    end else begin
      copy_r <= copy_s;
      err_r  <= err_s;
    end
  end

  assign out_err = err_r;
`endif

endmodule

// File: tb/tb_serial_neg_ctrl.sv
module tb_serial_neg_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic r_n;

  // DUT 0: Y_LAT=0 with a combinational complementer model
  logic       in_valid0, in_ready0, ser_i0, ser_r0, ser_y0;
  logic       out_valid0, out_ready0, out_ovf0, seen0;
  logic [7:0] in_data0, out_data0;
  // DUT 1: Y_LAT=1 with a one-cycle-registered complementer model
  logic       in_valid1, in_ready1, ser_i1, ser_r1, ser_y1;
  logic       out_valid1, out_ready1, out_ovf1, seen1;
  logic [7:0] in_data1, out_data1;
`ifdef SERIAL_NEG_SELFCHECK_EN
  logic       out_err0, out_err1;
`endif

  int checks   = 0;
  int failures = 0;

  serial_neg_ctrl #(.W(8), .Y_LAT(0)) dut0 (
    .t_clk     (clk),
    .r_n       (r_n),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .in_data   (in_data0),
    .ser_i     (ser_i0),
    .ser_r     (ser_r0),
    .ser_y     (ser_y0),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .out_data  (out_data0),
    .out_ovf   (out_ovf0)
`ifdef SERIAL_NEG_SELFCHECK_EN
    , .out_err (out_err0)
`endif
  );

  serial_neg_ctrl #(.W(8), .Y_LAT(1)) dut1 (
    .t_clk     (clk),
    .r_n       (r_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data1),
    .ser_i     (ser_i1),
    .ser_r     (ser_r1),
    .ser_y     (ser_y1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_data  (out_data1),
    .out_ovf   (out_ovf1)
`ifdef SERIAL_NEG_SELFCHECK_EN
    , .out_err (out_err1)
`endif
  );

  // Serial complementer: copy bits up to and including the first 1, invert after.
  assign ser_y0 = ser_i0 ^ seen0;
  always_ff @(posedge clk) begin
    if (ser_r0) seen0 <= 1'b0;
    else        seen0 <= seen0 | ser_i0;
  end

  // Same complementer with its output registered (one cycle latency).
  always_ff @(posedge clk) begin
    if (ser_r1) begin
      seen1  <= 1'b0;
      ser_y1 <= 1'b0;
    end else begin
      ser_y1 <= ser_i1 ^ seen1;
      seen1  <= seen1 | ser_i1;
    end
  end

  // Present a word at a negedge in IDLE; return the cycle index (accept cycle = 0)
  // at which out_valid is first seen, and how many cycles ser_r was low before it.
  task automatic send0(input logic [7:0] d, output logic acc, output int lat, output int rlow);
    acc = in_ready0;
    in_valid0 = 1'b1; in_data0 = d;
    @(negedge clk);
    in_valid0 = 1'b0; in_data0 = 8'h00;
    lat = 0; rlow = 0;
    for (int c = 1; c <= 30; c++) begin
      if (out_valid0) begin lat = c; break; end
      if (!ser_r0) rlow++;
      @(negedge clk);
    end
  endtask

  task automatic send1(input logic [7:0] d, output logic acc, output int lat, output int rlow);
    acc = in_ready1;
    in_valid1 = 1'b1; in_data1 = d;
    @(negedge clk);
    in_valid1 = 1'b0; in_data1 = 8'h00;
    lat = 0; rlow = 0;
    for (int c = 1; c <= 30; c++) begin
      if (out_valid1) begin lat = c; break; end
      if (!ser_r1) rlow++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    r_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready0, out_valid0, ser_r0, ser_i0, out_ovf0} !== 5'b10100) begin
      failures++; $display("FAIL reset_ctl0 got %b want 10100", {in_ready0, out_valid0, ser_r0, ser_i0, out_ovf0});
    end
    checks++;
    if (out_data0 !== 8'h00) begin failures++; $display("FAIL reset_data0 got %h want 00", out_data0); end
    checks++;
    if ({in_ready1, out_valid1, ser_r1, ser_i1, out_ovf1} !== 5'b10100) begin
      failures++; $display("FAIL reset_ctl1 got %b want 10100", {in_ready1, out_valid1, ser_r1, ser_i1, out_ovf1});
    end
`ifdef SERIAL_NEG_SELFCHECK_EN
    checks++;
    if (out_err0 !== 1'b0) begin failures++; $display("FAIL reset_err0 got %b want 0", out_err0); end
`endif
    r_n = 1'b1;
    @(negedge clk);
  endtask

  // Back-to-back words through the Y_LAT=0 unit with out_ready held high.
  task automatic test_words();
    logic [7:0] din  [6] = '{8'h01, 8'h5A, 8'h00, 8'h80, 8'hFF, 8'h7F};
    logic [7:0] dexp [6] = '{8'hFF, 8'hA6, 8'h00, 8'h80, 8'h01, 8'h81};
    logic       oexp [6] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
    logic acc; int lat, rlow;
    out_ready0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send0(din[i], acc, lat, rlow);
      checks++;
      if (acc !== 1'b1) begin failures++; $display("FAIL words_accept[%0d] got %b want 1", i, acc); end
      checks++;
      if (lat != 9) begin failures++; $display("FAIL words_latency[%0d] got %0d want 9", i, lat); end
      checks++;
      if (rlow != 8) begin failures++; $display("FAIL words_ser_r_low[%0d] got %0d want 8", i, rlow); end
      checks++;
      if (out_data0 !== dexp[i]) begin failures++; $display("FAIL words_data[%0d] got %h want %h", i, out_data0, dexp[i]); end
      checks++;
      if (out_ovf0 !== oexp[i]) begin failures++; $display("FAIL words_ovf[%0d] got %b want %b", i, out_ovf0, oexp[i]); end
      checks++;
      if (ser_r0 !== 1'b1) begin failures++; $display("FAIL words_ser_r_done[%0d] got %b want 1", i, ser_r0); end
`ifdef SERIAL_NEG_SELFCHECK_EN
      checks++;
      if (out_err0 !== 1'b0) begin failures++; $display("FAIL words_err[%0d] got %b want 0", i, out_err0); end
`endif
      @(negedge clk);
      checks++;
      if ({out_valid0, in_ready0, ser_r0} !== 3'b011) begin
        failures++; $display("FAIL words_idle_gap[%0d] got %b want 011", i, {out_valid0, in_ready0, ser_r0});
      end
    end
  endtask

  // Hold out_ready low in DONE while in_valid is asserted throughout.
  task automatic test_backpressure();
    out_ready0 = 1'b0;
    in_valid0 = 1'b1; in_data0 = 8'h33;
    @(negedge clk);
    in_data0 = 8'h55;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if ({in_ready0, out_valid0} !== 2'b00) begin
        failures++; $display("FAIL bp_shift_cycle%0d got %b want 00", c, {in_ready0, out_valid0});
      end
      @(negedge clk);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({out_valid0, in_ready0, out_ovf0, out_data0} !== {3'b100, 8'hCD}) begin
        failures++; $display("FAIL bp_hold%0d got v=%b r=%b o=%b d=%h want v=1 r=0 o=0 d=cd",
                             c, out_valid0, in_ready0, out_ovf0, out_data0);
      end
      @(negedge clk);
    end
    in_valid0 = 1'b0; in_data0 = 8'h00; out_ready0 = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid0, in_ready0} !== 2'b01) begin failures++; $display("FAIL bp_release got %b want 01", {out_valid0, in_ready0}); end
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid0, in_ready0} !== 2'b01) begin failures++; $display("FAIL bp_no_second got %b want 01", {out_valid0, in_ready0}); end
  endtask

  // Reset during SHIFT bit 4 discards the word; the next word is unaffected.
  task automatic test_reset_mid();
    logic acc; int lat, rlow; int seen_valid;
    in_valid0 = 1'b1; in_data0 = 8'h3C;
    @(negedge clk);
    in_valid0 = 1'b0; in_data0 = 8'h00;
    repeat (4) @(negedge clk);
    r_n = 1'b0;
    @(negedge clk);
    r_n = 1'b1;
    checks++;
    if ({in_ready0, out_valid0, ser_r0, ser_i0} !== 4'b1010) begin
      failures++; $display("FAIL rstmid_state got %b want 1010", {in_ready0, out_valid0, ser_r0, ser_i0});
    end
    seen_valid = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid0) seen_valid++;
      @(negedge clk);
    end
    checks++;
    if (seen_valid != 0) begin failures++; $display("FAIL rstmid_discard got %0d valid cycles want 0", seen_valid); end
    send0(8'h3C, acc, lat, rlow);
    checks++;
    if ((lat != 9) || (out_data0 !== 8'hC4) || (out_ovf0 !== 1'b0)) begin
      failures++; $display("FAIL rstmid_next got lat=%0d d=%h o=%b want lat=9 d=c4 o=0", lat, out_data0, out_ovf0);
    end
    @(negedge clk);
  endtask

  // Registered complementer path: one extra DRAIN cycle per word.
  task automatic test_ylat1();
    logic [7:0] din  [3] = '{8'h01, 8'h80, 8'h5A};
    logic [7:0] dexp [3] = '{8'hFF, 8'h80, 8'hA6};
    logic       oexp [3] = '{1'b0,  1'b1,  1'b0};
    logic acc; int lat, rlow;
    out_ready1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send1(din[i], acc, lat, rlow);
      checks++;
      if ((acc !== 1'b1) || (lat != 10)) begin
        failures++; $display("FAIL ylat1_latency[%0d] got acc=%b lat=%0d want acc=1 lat=10", i, acc, lat);
      end
      checks++;
      if (rlow != 9) begin failures++; $display("FAIL ylat1_ser_r_low[%0d] got %0d want 9", i, rlow); end
      checks++;
      if ((out_data1 !== dexp[i]) || (out_ovf1 !== oexp[i])) begin
        failures++; $display("FAIL ylat1_result[%0d] got d=%h o=%b want d=%h o=%b", i, out_data1, out_ovf1, dexp[i], oexp[i]);
      end
`ifdef SERIAL_NEG_SELFCHECK_EN
      checks++;
      if (out_err1 !== 1'b0) begin failures++; $display("FAIL ylat1_err[%0d] got %b want 0", i, out_err1); end
`endif
      @(negedge clk);
      checks++;
      if ({out_valid1, in_ready1} !== 2'b01) begin failures++; $display("FAIL ylat1_idle[%0d] got %b want 01", i, {out_valid1, in_ready1}); end
    end
  endtask

  initial begin
    r_n = 1'b0;
    in_valid0 = 1'b0; in_data0 = 8'h00; out_ready0 = 1'b1;
    in_valid1 = 1'b0; in_data1 = 8'h00; out_ready1 = 1'b1;
    @(negedge clk);
    test_reset();
    test_words();
    test_backpressure();
    test_reset_mid();
    test_ylat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
